// File: rtl/operand2_decoder_pkg.sv
// Shared types for the operand-2 decoder: shifter opcodes,
// FSM states, instruction field positions and the control bundle.
package op2_pkg;

  localparam logic [2:0] SH_LSL = 3'd0;
  localparam logic [2:0] SH_LSR = 3'd1;
  localparam logic [2:0] SH_ASR = 3'd2;
  localparam logic [2:0] SH_ROR = 3'd3;
  localparam logic [2:0] SH_RRX = 3'd4;

  localparam int B_IMM   = 25;
  localparam int B_REGSH = 4;
  localparam int B_R7    = 7;
  localparam int RS_HI   = 11;
  localparam int RS_LO   = 8;
  localparam int AMT_HI  = 11;
  localparam int AMT_LO  = 7;
  localparam int TY_HI   = 6;
  localparam int TY_LO   = 5;

  typedef enum logic [1:0] {
    IDLE,
    RS_REQ,
    RS_WAIT,
    OUT
  } state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [4:0]  amount;
    logic        ge32;
    logic        carry;
    logic        op_imm;
    logic [31:0] value;
    logic [3:0]  rm;
    logic        undef;
  } ctl_t;

endpackage

// File: rtl/operand2_decoder_if.sv
// Handshake and data bundle between decode, register file
// and shifter for the operand-2 decoder.
interface operand2_decoder_if #(
  parameter int RF_ADDR_W = 4
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr;
  logic                 cflag_in;
  logic                 rs_rd_en;
  logic [RF_ADDR_W-1:0] rs_rd_addr;
  logic                 rs_rd_valid;
  logic [31:0]          rs_rd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           sh_opcode;
  logic [4:0]           sh_amount;
  logic                 sh_ge32;
  logic                 sh_carry_in;
  logic                 op_imm;
  logic [31:0]          op_value;
  logic [RF_ADDR_W-1:0] rm_addr;
  logic                 undef;

  modport master (
    output in_valid, instr, cflag_in,
    output rs_rd_valid, rs_rd_data,
    output out_ready,
    input  in_ready, rs_rd_en, rs_rd_addr,
    input  out_valid, sh_opcode, sh_amount,
    input  sh_ge32, sh_carry_in, op_imm,
    input  op_value, rm_addr, undef
  );

  modport slave (
    input  in_valid, instr, cflag_in,
    input  rs_rd_valid, rs_rd_data,
    input  out_ready,
    output in_ready, rs_rd_en, rs_rd_addr,
    output out_valid, sh_opcode, sh_amount,
    output sh_ge32, sh_carry_in, op_imm,
    output op_value, rm_addr, undef
  );

endinterface

// File: rtl/operand2_decoder_field_decode.sv
// Combinational operand-2 field decode into a shifter control bundle.
// Register-shift support is built only with OP2_REGSHIFT_EN defined.
module op2_field_decode
  import op2_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        cflag,
  input  logic [31:0] rs_data,
  output ctl_t        ctl,
  output logic        needs_rs
);

  logic [1:0] ty;
  logic [4:0] amt;
  logic       is_imm;
  logic       is_ish;
  logic       is_und;
  logic       is_reg;
  logic       unused_ok;

  assign ty  = instr[TY_HI:TY_LO];
  assign amt = instr[AMT_HI:AMT_LO];

  assign is_imm = instr[B_IMM];
  assign is_ish = !instr[B_IMM] && !instr[B_REGSH];
  assign is_und = !instr[B_IMM] && instr[B_REGSH] &&
                  instr[B_R7];
  assign is_reg = !instr[B_IMM] && instr[B_REGSH] &&
                  !instr[B_R7];

`ifdef OP2_REGSHIFT_EN
  logic [7:0] s;
  assign s = rs_data[7:0];
  assign unused_ok = ^{instr[31:26], instr[24:12],
                       rs_data[31:8]};
`else
  assign unused_ok = ^{instr[31:26], instr[24:12],
                       rs_data};
`endif

  always_comb begin
    ctl      = '0;
    needs_rs = 1'b0;
    unique case (1'b1)
      is_imm: begin
        ctl.op_imm = 1'b1;
        ctl.value  = {24'b0, instr[7:0]};
        ctl.opcode = SH_ROR;
        ctl.amount = {instr[RS_HI:RS_LO], 1'b0};
        ctl.carry  = cflag;
        ctl.rm     = instr[3:0];
      end
      is_ish: begin
        ctl.carry = cflag;
        ctl.rm    = instr[3:0];
        // amount 0 re-encodes: LSR/ASR mean 32, ROR means RRX
        if (amt == 5'd0 && ty == 2'd3) begin
          ctl.opcode = SH_RRX;
        end else begin
          ctl.opcode = {1'b0, ty};
          ctl.amount = amt;
          ctl.ge32   = (amt == 5'd0) &&
                       (ty == 2'd1 || ty == 2'd2);
        end
      end
      is_und: begin
        ctl.undef = 1'b1;
      end
      is_reg: begin
`ifdef OP2_REGSHIFT_EN
        needs_rs  = 1'b1;
        ctl.carry = cflag;
        ctl.rm    = instr[3:0];
        if (s != 8'd0) begin
          ctl.opcode = {1'b0, ty};
          ctl.amount = s[4:0];
          ctl.ge32   = (ty != 2'd3) && (|s[7:5]);
        end
`else
        ctl.undef = 1'b1;
`endif
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

endmodule

// File: rtl/operand2_decoder.sv
// Operand-2 sequencer: handshakes, Rs fetch FSM, output registers.
// Define OP2_REGSHIFT_EN to build register-specified shift support.
module operand2_decoder
  import op2_pkg::*;
#(
  parameter int RF_ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  operand2_decoder_if.slave  bus
);

  state_t      state;
  logic [31:0] instr_q;
  logic        cflag_q;
  ctl_t        ctl;
  ctl_t        ctl_q;
  logic        needs_rs;
  logic [31:0] dec_instr;
  logic        dec_cf;
  logic        take;

  assign bus.in_ready = (state == IDLE) ||
                        (state == OUT && bus.out_ready);
  assign take = bus.in_valid && bus.in_ready;

  // RS_WAIT decodes the held word; otherwise the incoming one
  assign dec_instr = (state == RS_WAIT) ? instr_q : bus.instr;
  assign dec_cf    = (state == RS_WAIT) ? cflag_q : bus.cflag_in;

  op2_field_decode u_dec (
    .instr    (dec_instr),
    .cflag    (dec_cf),
    .rs_data  (bus.rs_rd_data),
    .ctl      (ctl),
    .needs_rs (needs_rs)
  );

  assign bus.sh_opcode   = ctl_q.opcode;
  assign bus.sh_amount   = ctl_q.amount;
  assign bus.sh_ge32     = ctl_q.ge32;
  assign bus.sh_carry_in = ctl_q.carry;
  assign bus.op_imm      = ctl_q.op_imm;
  assign bus.op_value    = ctl_q.value;
  assign bus.rm_addr     = RF_ADDR_W'(ctl_q.rm);
  assign bus.undef       = ctl_q.undef;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      instr_q       <= '0;
      cflag_q       <= 1'b0;
      ctl_q         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, OUT: begin
          if (state == IDLE || bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
          if (take) begin
            instr_q <= bus.instr;
            cflag_q <= bus.cflag_in;
`ifdef OP2_REGSHIFT_EN
            if (needs_rs) begin
              state <= RS_REQ;
            end else begin
              ctl_q         <= ctl;
              bus.out_valid <= 1'b1;
              state         <= OUT;
            end
`else
            ctl_q         <= ctl;
            bus.out_valid <= 1'b1;
            state         <= OUT;
`endif
          end
        end
`ifdef OP2_REGSHIFT_EN
        RS_REQ: begin
          state <= RS_WAIT;
        end
        RS_WAIT: begin
          if (bus.rs_rd_valid) begin
            ctl_q         <= ctl;
            bus.out_valid <= 1'b1;
            state         <= OUT;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef OP2_REGSHIFT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rs_rd_en   <= 1'b0;
      bus.rs_rd_addr <= '0;
    end else begin
      bus.rs_rd_en <= take && needs_rs;
      if (take && needs_rs) begin
        bus.rs_rd_addr <= RF_ADDR_W'(bus.instr[RS_HI:RS_LO]);
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok      = bus.rs_rd_valid ^ needs_rs;
  assign bus.rs_rd_en   = 1'b0;
  assign bus.rs_rd_addr = '0;
`endif

endmodule
